// File: rtl/fetch_pkg.sv
// fetch_pkg: shared constants and the prefetch-queue entry type for the fetch unit.
package fetch_pkg;

    localparam int unsigned XLEN_DEFAULT = 32;
    localparam logic [31:0] NOP_INST     = 32'h0000_0013;

    typedef struct packed {
        logic [XLEN_DEFAULT-1:0] pc;
        logic [31:0]             inst;
        logic                    misalign;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: DEPTH-entry synchronous FIFO of fetch entries with flush and
// first-word-fall-through read side.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int unsigned DEPTH   = 4,
    parameter type         entry_t = fetch_entry_t
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       flush_i,
    input  logic                       push_i,
    input  entry_t                     data_i,
    input  logic                       pop_i,
    output entry_t                     head_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH):0]     count_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    entry_t          mem_q [DEPTH];
    logic [AW-1:0]   rd_q;
    logic [AW-1:0]   wr_q;
    logic [CW-1:0]   cnt_q;
    logic            push_ok;
    logic            pop_ok;

    assign push_ok = push_i && (flush_i || (cnt_q != FULL_CNT));
    assign pop_ok  = pop_i && (cnt_q != '0) && !flush_i;

    // A push during flush lands in slot 0 so the queue restarts holding exactly that entry.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (flush_i) begin
            rd_q <= '0;
            if (push_ok) begin
                mem_q[0] <= data_i;
                wr_q     <= AW'(1);
                cnt_q    <= CW'(1);
            end else begin
                wr_q  <= '0;
                cnt_q <= '0;
            end
        end else begin
            if (push_ok) begin
                mem_q[wr_q] <= data_i;
                wr_q        <= wr_q + AW'(1);
            end
            if (pop_ok) begin
                rd_q <= rd_q + AW'(1);
            end
            cnt_q <= cnt_q + CW'(push_ok) - CW'(pop_ok);
        end
    end

    assign head_o  = mem_q[rd_q];
    assign empty_o = (cnt_q == '0);
    assign count_o = cnt_q;

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: PC generator, credit-limited imem requester and prefetch queue feeding decode.
// Optional macro FETCH_MISALIGN_CHECK_EN turns misaligned redirects into a single fault entry.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int unsigned     XLEN         = XLEN_DEFAULT,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0,
    parameter int unsigned     DEPTH        = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [31:0]     imem_rsp_data,
    output logic            dec_valid,
    input  logic            dec_ready,
    output logic [XLEN-1:0] dec_pc,
`ifdef FETCH_MISALIGN_CHECK_EN
    output logic            dec_misalign,
`endif
    output logic [31:0]     dec_inst
);

    localparam int unsigned   CW    = $clog2(DEPTH) + 1;
    localparam logic [CW:0]   LIMIT = (CW+1)'(DEPTH);

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [31:0]     inst;
`ifdef FETCH_MISALIGN_CHECK_EN
        logic            misalign;
`endif
    } entry_t;

    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic [XLEN-1:0] rsp_pc_q, rsp_pc_d;
    logic [CW-1:0]   outstanding_q, outstanding_d;
    logic [CW-1:0]   discard_q, discard_d;

    logic [XLEN-1:0] target;
    logic            fetch_halt;
    logic [CW-1:0]   count;
    logic [CW:0]     inflight;
    logic            req_fire;
    logic            rsp_fire;
    logic            rsp_drop;
    logic            fifo_push;
    logic            fifo_pop;
    logic            fifo_empty;
    entry_t          push_entry;
    entry_t          head;

`ifdef FETCH_MISALIGN_CHECK_EN
    logic            halt_q, halt_d;
    logic            mis;

    assign target     = redirect_pc;
    assign mis        = |redirect_pc[1:0];
    assign fetch_halt = halt_q;
`else
    localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);

    assign target     = redirect_pc & ALIGN_MASK;
    assign fetch_halt = 1'b0;
`endif

    // Stale responses still in flight hold credit until they drain, so the queue cannot overflow.
    assign inflight       = {1'b0, outstanding_q} + {1'b0, count};
    assign imem_req_valid = !rst && !redirect_valid && !fetch_halt && (inflight < LIMIT);
    assign imem_req_addr  = fetch_pc_q;
    assign req_fire       = imem_req_valid && imem_req_ready;

    assign rsp_fire = imem_rsp_valid && (outstanding_q != '0);
    assign rsp_drop = rsp_fire && (redirect_valid || (discard_q != '0));

`ifdef FETCH_MISALIGN_CHECK_EN
    assign fifo_push = (rsp_fire && !rsp_drop) || (redirect_valid && mis);
`else
    assign fifo_push = rsp_fire && !rsp_drop;
`endif
    assign fifo_pop  = dec_valid && dec_ready && !redirect_valid;

    always_comb begin
        push_entry      = '0;
        push_entry.pc   = rsp_pc_q;
        push_entry.inst = imem_rsp_data;
`ifdef FETCH_MISALIGN_CHECK_EN
        if (redirect_valid) begin
            push_entry.pc       = target;
            push_entry.inst     = NOP_INST;
            push_entry.misalign = 1'b1;
        end
`endif
    end

    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        rsp_pc_d      = rsp_pc_q;
        outstanding_d = outstanding_q;
        discard_d     = discard_q;
`ifdef FETCH_MISALIGN_CHECK_EN
        halt_d        = halt_q;
`endif
        if (redirect_valid) begin
            fetch_pc_d    = target;
            rsp_pc_d      = target;
            outstanding_d = outstanding_q - CW'(rsp_fire);
            discard_d     = outstanding_q - CW'(rsp_fire);
`ifdef FETCH_MISALIGN_CHECK_EN
            halt_d        = mis;
`endif
        end else begin
            if (req_fire) begin
                fetch_pc_d = fetch_pc_q + XLEN'(4);
            end
            if (rsp_fire) begin
                if (discard_q != '0) begin
                    discard_d = discard_q - CW'(1);
                end else begin
                    rsp_pc_d = rsp_pc_q + XLEN'(4);
                end
            end
            outstanding_d = outstanding_q + CW'(req_fire) - CW'(rsp_fire);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc_q    <= RESET_VECTOR;
            rsp_pc_q      <= RESET_VECTOR;
            outstanding_q <= '0;
            discard_q     <= '0;
`ifdef FETCH_MISALIGN_CHECK_EN
            halt_q        <= 1'b0;
`endif
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            rsp_pc_q      <= rsp_pc_d;
            outstanding_q <= outstanding_d;
            discard_q     <= discard_d;
`ifdef FETCH_MISALIGN_CHECK_EN
            halt_q        <= halt_d;
`endif
        end
    end

    fetch_fifo #(
        .DEPTH   (DEPTH),
        .entry_t (entry_t)
    ) u_fifo (
        .clk_i   (clk),
        .rst_i   (rst),
        .flush_i (redirect_valid),
        .push_i  (fifo_push),
        .data_i  (push_entry),
        .pop_i   (fifo_pop),
        .head_o  (head),
        .empty_o (fifo_empty),
        .count_o (count)
    );

    assign dec_valid = !fifo_empty;
    assign dec_pc    = head.pc;
    assign dec_inst  = head.inst;
`ifdef FETCH_MISALIGN_CHECK_EN
    assign dec_misalign = dec_valid && head.misalign;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed self-checking bench for fetch_unit with an in-order
// one-cycle instruction memory model.
module tb_fetch_unit;

    logic        clk;
    logic        rst;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        dec_valid;
    logic        dec_ready;
    logic [31:0] dec_pc;
    logic [31:0] dec_inst;
`ifdef FETCH_MISALIGN_CHECK_EN
    logic        dec_misalign;
`endif

    int unsigned n_checks;
    int unsigned n_errors;
    int unsigned n_req;
    logic        rsp_en;
    logic [31:0] mq[$];

    fetch_unit #(
        .XLEN         (32),
        .RESET_VECTOR (32'h0000_0000),
        .DEPTH        (4)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .dec_valid      (dec_valid),
        .dec_ready      (dec_ready),
        .dec_pc         (dec_pc),
`ifdef FETCH_MISALIGN_CHECK_EN
        .dec_misalign   (dec_misalign),
`endif
        .dec_inst       (dec_inst)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    function automatic logic [31:0] inst_of(input logic [31:0] a);
        return {16'hC0DE, a[15:0]};
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive_rsp();
        imem_rsp_valid = rsp_en && (mq.size() != 0);
        imem_rsp_data  = imem_rsp_valid ? inst_of(mq[0]) : 32'h0;
    endtask

    // Samples handshakes mid-cycle, advances one clock, then updates the memory model.
    task automatic tick();
        logic        rf;
        logic        rv;
        logic [31:0] ra;
        @(negedge clk);
        rf = imem_req_valid && imem_req_ready;
        ra = imem_req_addr;
        rv = imem_rsp_valid;
        @(posedge clk);
        #1;
        if (rv && mq.size() != 0) void'(mq.pop_front());
        if (rf) begin
            mq.push_back(ra);
            n_req++;
        end
        drive_rsp();
    endtask

    task automatic do_reset();
        rst            = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        dec_ready      = 1'b0;
        imem_req_ready = 1'b1;
        rsp_en         = 1'b0;
        mq.delete();
        drive_rsp();
        tick();
        tick();
        rst       = 1'b0;
        n_req     = 0;
        rsp_en    = 1'b1;
        dec_ready = 1'b1;
        drive_rsp();
        #1;
    endtask

    task automatic redirect_cycle(input logic [31:0] pc);
        redirect_valid = 1'b1;
        redirect_pc    = pc;
        #1;
        check("req_valid_in_redirect", imem_req_valid, 1'b0);
        tick();
        redirect_valid = 1'b0;
        #1;
    endtask

    initial begin
        logic [31:0] first_pc;
        logic        got_first;
        int unsigned old_seen;
        int unsigned n0;

        n_checks = 0;
        n_errors = 0;
        n_req    = 0;

        rst            = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        dec_ready      = 1'b0;
        imem_req_ready = 1'b1;
        rsp_en         = 1'b0;
        drive_rsp();
        #1;
        check("rst_req_valid", imem_req_valid, 1'b0);
        check("rst_dec_valid", dec_valid, 1'b0);
        check("rst_req_addr", imem_req_addr, 32'h0);
`ifdef FETCH_MISALIGN_CHECK_EN
        check("rst_dec_misalign", dec_misalign, 1'b0);
`endif

        // Streaming from reset: requests 0,4,8..., decode sees PC 0 in cycle 3 then one per cycle.
        do_reset();
        check("c1_req_valid", imem_req_valid, 1'b1);
        check("c1_req_addr", imem_req_addr, 32'h0);
        tick();
        check("c2_req_addr", imem_req_addr, 32'h4);
        check("c2_dec_valid", dec_valid, 1'b0);
        tick();
        for (int k = 0; k < 6; k++) begin
            check("stream_dec_valid", dec_valid, 1'b1);
            check("stream_dec_pc", dec_pc, 32'(4 * k));
            check("stream_dec_inst", dec_inst, inst_of(32'(4 * k)));
            tick();
        end

        // Decode stalled: exactly DEPTH requests, then a single pop frees one credit.
        do_reset();
        dec_ready = 1'b0;
        for (int k = 0; k < 12; k++) tick();
        check("bp_req_count", n_req, 4);
        check("bp_req_valid", imem_req_valid, 1'b0);
        check("bp_dec_valid", dec_valid, 1'b1);
        check("bp_dec_pc", dec_pc, 32'h0);
        dec_ready = 1'b1;
        tick();
        dec_ready = 1'b0;
        #1;
        check("bp_pop_dec_pc", dec_pc, 32'h4);
        check("bp_pop_req_valid", imem_req_valid, 1'b1);
        check("bp_pop_req_addr", imem_req_addr, 32'h10);

        // Redirect with three requests outstanding: their responses must never reach decode.
        do_reset();
        rsp_en = 1'b0;
        drive_rsp();
        tick();
        tick();
        tick();
        check("rd3_req_count", n_req, 3);
        redirect_cycle(32'h100);
        check("rd3_req_addr", imem_req_addr, 32'h100);
        rsp_en = 1'b1;
        drive_rsp();
        got_first = 1'b0;
        first_pc  = 32'h0;
        old_seen  = 0;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (dec_valid && !got_first) begin
                got_first = 1'b1;
                first_pc  = dec_pc;
                check("rd3_first_inst", dec_inst, inst_of(32'h100));
            end
            if (dec_valid && dec_pc < 32'h100) old_seen++;
        end
        check("rd3_got_first", got_first, 1'b1);
        check("rd3_first_pc", first_pc, 32'h100);
        check("rd3_old_seen", old_seen, 0);

        // Redirect coinciding with a response and a pop.
        do_reset();
        tick();
        tick();
        tick();
        check("rsp_pop_pre_dec_pc", dec_pc, 32'h4);
        check("rsp_pop_pre_rsp", imem_rsp_valid, 1'b1);
        redirect_cycle(32'h100);
        check("rsp_pop_dec_valid", dec_valid, 1'b0);
        check("rsp_pop_req_valid", imem_req_valid, 1'b1);
        check("rsp_pop_req_addr", imem_req_addr, 32'h100);
        tick();
        tick();
        check("rsp_pop_dec_valid2", dec_valid, 1'b1);
        check("rsp_pop_dec_pc2", dec_pc, 32'h100);

        // Address wrap at 2^32.
        do_reset();
        tick();
        tick();
        redirect_cycle(32'hFFFF_FFF8);
        check("wrap_addr0", imem_req_addr, 32'hFFFF_FFF8);
        tick();
        check("wrap_addr1", imem_req_addr, 32'hFFFF_FFFC);
        tick();
        check("wrap_addr2", imem_req_addr, 32'h0);
        check("wrap_dec_pc0", dec_pc, 32'hFFFF_FFF8);
        tick();
        check("wrap_dec_pc1", dec_pc, 32'hFFFF_FFFC);
        tick();
        check("wrap_dec_pc2", dec_pc, 32'h0);

`ifdef FETCH_MISALIGN_CHECK_EN
        // Misaligned redirect yields one fault entry and halts fetch.
        do_reset();
        dec_ready = 1'b0;
        redirect_cycle(32'h102);
        check("mis_dec_valid", dec_valid, 1'b1);
        check("mis_dec_pc", dec_pc, 32'h102);
        check("mis_dec_inst", dec_inst, 32'h0000_0013);
        check("mis_dec_misalign", dec_misalign, 1'b1);
        check("mis_req_valid", imem_req_valid, 1'b0);
        n0 = n_req;
        dec_ready = 1'b1;
        tick();
        check("mis_after_pop_valid", dec_valid, 1'b0);
        for (int k = 0; k < 4; k++) tick();
        check("mis_halt_req_count", n_req, n0);
        check("mis_halt_req_valid", imem_req_valid, 1'b0);
        redirect_cycle(32'h200);
        check("mis_resume_req_valid", imem_req_valid, 1'b1);
        check("mis_resume_req_addr", imem_req_addr, 32'h200);
`else
        // Without the fault check, low target bits are ignored.
        do_reset();
        tick();
        tick();
        redirect_cycle(32'h102);
        check("align_req_addr", imem_req_addr, 32'h100);
        n0 = n_req;
        tick();
        tick();
        check("align_dec_pc", dec_pc, 32'h100);
        check("align_req_count", n_req, n0 + 2);
`endif

        // Asynchronous reset with two outstanding and two queued entries.
        do_reset();
        dec_ready = 1'b0;
        rsp_en    = 1'b0;
        drive_rsp();
        for (int k = 0; k < 4; k++) tick();
        rsp_en = 1'b1;
        drive_rsp();
        tick();
        tick();
        check("ar_pre_dec_valid", dec_valid, 1'b1);
        check("ar_pre_req_valid", imem_req_valid, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        check("ar_dec_valid", dec_valid, 1'b0);
        check("ar_req_valid", imem_req_valid, 1'b0);
        check("ar_req_addr", imem_req_addr, 32'h0);
        do_reset();
        check("ar_restart_req_valid", imem_req_valid, 1'b1);
        check("ar_restart_req_addr", imem_req_addr, 32'h0);
        tick();
        tick();
        check("ar_restart_dec_valid", dec_valid, 1'b1);
        check("ar_restart_dec_pc", dec_pc, 32'h0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter XLEN, default 32: PC and address width.
REQ-002 Parameter RESET_VECTOR, default 32'h0000_0000: first fetch address after reset.
REQ-003 Parameter DEPTH, default 4: prefetch queue entries and outstanding-request limit; power of two, >= 2.
REQ-004 clk  input  1  single clock, all state on rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 redirect_valid  input  1  branch/jump taken; flush and refetch from redirect_pc.
REQ-007 redirect_pc  input  XLEN  redirect target.
REQ-008 imem_req_valid  output  1  instruction memory request.
REQ-009 imem_req_ready  input  1  memory accepts request.
REQ-010 imem_req_addr  output  XLEN  request address.
REQ-011 imem_rsp_valid  input  1  in-order response strobe, one per accepted request.
REQ-012 imem_rsp_data  input  32  fetched instruction.
REQ-013 dec_valid  output  1  instruction available to decode.
REQ-014 dec_ready  input  1  decode consumes instruction.
REQ-015 dec_pc  output  XLEN  PC of presented instruction.
REQ-016 dec_inst  output  32  presented instruction.
REQ-017 dec_misalign  output  1  present only with FETCH_MISALIGN_CHECK_EN; presented entry is a misaligned-target fault.

Function
REQ-018 fetch_pc register holds the next request address; imem_req_addr = fetch_pc.
REQ-019 imem_req_valid = !redirect_valid && (outstanding + occupancy < DEPTH); credit rule guarantees queue never overflows.
REQ-020 Request handshake (valid && ready): fetch_pc += 4, outstanding += 1; wrap at 2^XLEN.
REQ-021 rsp_pc register tracks PC of oldest live outstanding request; accepted response pushes {rsp_pc, imem_rsp_data} into queue, rsp_pc += 4, outstanding -= 1.
REQ-022 Queue is registered FIFO: response at cycle M visible on dec_valid/dec_pc/dec_inst at M+1; first-word-fall-through on read side.
REQ-023 dec_valid = queue not empty; pop on dec_valid && dec_ready; simultaneous push and pop keeps occupancy constant.
REQ-024 Redirect at cycle N: queue flushed, fetch_pc and rsp_pc <= redirect_pc, discard_cnt <= outstanding (including any request accepted in cycle N is impossible: req_valid low); first new request at N+1.
REQ-025 While discard_cnt > 0, arriving responses are dropped and decrement both discard_cnt and outstanding; a response in the redirect cycle itself is counted as stale and dropped.
REQ-026 Redirect has priority over dec_ready pop and response push in the same cycle.
REQ-027 Response with outstanding == 0 is a protocol violation; ignored, no state change.
REQ-028 Throughput: with imem_req_ready=1, 1-cycle response latency and dec_ready=1, one instruction per cycle sustained.

Reset
REQ-029 On rst: fetch_pc = rsp_pc = RESET_VECTOR, queue empty, outstanding = discard_cnt = 0, dec_valid = 0, imem_req_valid = 0 while rst high, dec_misalign = 0.
REQ-030 Reset mid-operation discards all in-flight state; memory is reset by the same rst, no stale responses expected.

Configuration
REQ-031 Macro FETCH_MISALIGN_CHECK_EN defined: redirect_pc[1:0] != 0 flushes as normal, issues no requests, presents one entry {pc=redirect_pc, inst=32'h0000_0013, dec_misalign=1}; after it is consumed fetch halts until next redirect.
REQ-032 Macro undefined: redirect_pc[1:0] forced to 2'b00, dec_misalign port absent.

Structure
REQ-033 Package fetch_pkg: NOP_INST constant 32'h0000_0013, fetch entry struct {pc, inst, misalign}, default XLEN localparam.
REQ-034 Sub-module fetch_fifo: parametrised DEPTH synchronous FIFO of fetch entries with push, pop, flush, empty, count.

Verification
REQ-035 Reset then imem_req_ready=1, 1-cycle memory -> requests 0x0,0x4,0x8...; dec_pc 0x0 first at cycle 3, one per cycle after.
REQ-036 dec_ready=0 with DEPTH=4 -> exactly 4 requests issued, imem_req_valid low until a pop.
REQ-037 Redirect to 0x100 with 3 outstanding -> 3 responses dropped, next dec_pc = 0x100, no old PC ever presented.
REQ-038 Redirect and response and pop same cycle -> response dropped, queue empty next cycle, request 0x100 next cycle.
REQ-039 With FETCH_MISALIGN_CHECK_EN, redirect to 0x102 -> single entry pc 0x102, inst 0x00000013, dec_misalign=1, no imem requests.
REQ-040 rst asserted with 2 outstanding and queue half full -> all outputs at reset values asynchronously, restart at RESET_VECTOR.
